// File: rtl/tm_lif_pkg.sv
// Shared definitions for the time-multiplexed LIF neuron array.
// Covers reset-mode encodings and a width-generic saturating adder.
package tm_lif_pkg;

    localparam logic MODE_ZERO = 1'b0;
    localparam logic MODE_SUB  = 1'b1;

    // The result keeps all 33 bits so callers can use it directly in wide compares.
    function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/lif_core.sv
// Combinational single-neuron update: leak, saturating integrate, fire/reset, refractory countdown.
// Zero latency; no handshake, the array decides when a result is committed.
module lif_core
    import tm_lif_pkg::*;
#(
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int RW         = 2
) (
    input  logic [W-1:0]  state_i,
    input  logic [W-1:0]  current_i,
    input  logic [W-1:0]  thr_i,
    input  logic [RW-1:0] refrac_i,
    input  logic          mode_i,
    output logic [W-1:0]  state_o,
    output logic [RW-1:0] refrac_o,
    output logic          fire_o
);

    logic [W-1:0] leak;
    logic [32:0]  sum_wide;
    logic [W-1:0] sum;

    assign leak     = state_i >> LEAK_SHIFT;
    assign sum_wide = sat_add(32'(leak), 32'(current_i), W);
    assign sum      = sum_wide[W-1:0];

    always_comb begin
        state_o  = sum;
        refrac_o = '0;
        fire_o   = 1'b0;
        if (refrac_i != '0) begin
            // Refractory neurons only leak; input current is discarded.
            state_o  = leak;
            refrac_o = refrac_i - RW'(1);
        end else if (sum_wide >= 33'(thr_i)) begin
            fire_o   = 1'b1;
            state_o  = (mode_i == MODE_SUB) ? (sum - thr_i) : '0;
            refrac_o = RW'(REFRAC);
        end
    end

endmodule

// File: rtl/tm_lif_array.sv
// N-neuron LIF array sharing one lif_core, scanning one neuron per enabled cycle.
// Outputs registered, valid one cycle after the update edge; no backpressure, en alone gates the scan.
module tm_lif_array
    import tm_lif_pkg::*;
#(
    parameter int N           = 8,
    parameter int W           = 8,
    parameter int LEAK_SHIFT  = 1,
    parameter int THRESH_INIT = 127,
    parameter int REFRAC      = 2,
    localparam int IDXW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N*W-1:0]  current,
    input  logic            mode,
    input  logic            cfg_we,
    input  logic [IDXW-1:0] cfg_addr,
    input  logic [W-1:0]    cfg_thresh,
    output logic [N-1:0]    spike,
    output logic            spike_evt,
    output logic [IDXW-1:0] spike_idx,
    output logic [W-1:0]    state_out,
    output logic            frame_done
);

    localparam int              RW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    logic [W-1:0]    state_q  [N];
    logic [W-1:0]    thr_q    [N];
    logic [RW-1:0]   refrac_q [N];
    logic [IDXW-1:0] idx_q, idx_d;
    logic [N-1:0]    spike_q;
    logic            evt_q, fdone_q;
    logic [IDXW-1:0] sidx_q;
    logic [W-1:0]    sout_q;

    logic [W-1:0]    cur_sel;
    logic [W-1:0]    core_state;
    logic [RW-1:0]   core_refrac;
    logic            core_fire;

    assign cur_sel = current[int'(idx_q) * W +: W];
    assign idx_d   = (idx_q == LAST) ? '0 : idx_q + IDXW'(1);

    lif_core #(
        .W          (W),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC     (REFRAC),
        .RW         (RW)
    ) u_core (
        .state_i   (state_q[idx_q]),
        .current_i (cur_sel),
        .thr_i     (thr_q[idx_q]),
        .refrac_i  (refrac_q[idx_q]),
        .mode_i    (mode),
        .state_o   (core_state),
        .refrac_o  (core_refrac),
        .fire_o    (core_fire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                state_q[i]  <= '0;
                thr_q[i]    <= W'(THRESH_INIT);
                refrac_q[i] <= '0;
            end
            idx_q   <= '0;
            spike_q <= '0;
            evt_q   <= 1'b0;
            fdone_q <= 1'b0;
            sidx_q  <= '0;
            sout_q  <= '0;
        end else begin
            evt_q   <= 1'b0;
            fdone_q <= 1'b0;
            if (en) begin
                state_q[idx_q]  <= core_state;
                refrac_q[idx_q] <= core_refrac;
                spike_q[idx_q]  <= core_fire;
                evt_q           <= core_fire;
                sidx_q          <= idx_q;
                sout_q          <= core_state;
                fdone_q         <= (idx_q == LAST);
                idx_q           <= idx_d;
            end
            // The core already read the old threshold this edge, so a same-edge write lands next frame.
            if (cfg_we && (cfg_addr <= LAST)) begin
                thr_q[cfg_addr] <= cfg_thresh;
            end
        end
    end

    assign spike      = spike_q;
    assign spike_evt  = evt_q;
    assign spike_idx  = sidx_q;
    assign state_out  = sout_q;
    assign frame_done = fdone_q;

endmodule
